// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO, plus single-cycle MTHI/MTLO.
// Optional MDU_FAST_MUL_EN: multiplies skip CALC and use a combinational multiplier.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       md_op,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX
    } state_t;

    state_t state, next_state;

    logic [CW-1:0]      count;
    logic [WIDTH-1:0]   acc_hi;
    logic [WIDTH-1:0]   acc_lo;
    logic [WIDTH-1:0]   operand_b;
    logic               is_div;
    logic               neg_main;
    logic               neg_rem;
    logic               div_zero;

    logic               accept_op;
    logic               signed_op;
    logic               sign_a;
    logic               sign_b;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;

    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     rem_shift;
    logic [WIDTH:0]     rem_diff;
    logic [2*WIDTH-1:0] mul_next;
    logic [2*WIDTH-1:0] div_next;
    logic [2*WIDTH-1:0] product;
    logic [2*WIDTH-1:0] prod_signed;
    logic [WIDTH-1:0]   quot_fixed;
    logic [WIDTH-1:0]   rem_fixed;
    logic [WIDTH-1:0]   fix_hi;
    logic [WIDTH-1:0]   fix_lo;

    // Signed ops work on magnitudes; the signs are reapplied in FIX.
    always_comb begin
        accept_op = start && (state == IDLE) && (md_op < 3'd4);
        signed_op = ~md_op[0];
        sign_a    = signed_op & rs_val[WIDTH-1];
        sign_b    = signed_op & rt_val[WIDTH-1];
        mag_a     = sign_a ? -rs_val : rs_val;
        mag_b     = sign_b ? -rt_val : rt_val;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (accept_op) begin
`ifdef MDU_FAST_MUL_EN
                    next_state = md_op[1] ? CALC : FIX;
`else
                    next_state = CALC;
`endif
                end
            end
            CALC: begin
                if (count == '0) begin
                    next_state = FIX;
                end
            end
            FIX:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // {acc_hi, acc_lo} is the product shifting right for multiply, and the
    // remainder:dividend pair shifting left for restoring division.
    always_comb begin
        mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, operand_b} : {(WIDTH+1){1'b0}});
        mul_next  = {mul_sum, acc_lo[WIDTH-1:1]};
        rem_shift = {acc_hi, acc_lo[WIDTH-1]};
        rem_diff  = rem_shift - {1'b0, operand_b};
        if (rem_diff[WIDTH]) begin
            div_next = {rem_shift[WIDTH-1:0], acc_lo[WIDTH-2:0], 1'b0};
        end else begin
            div_next = {rem_diff[WIDTH-1:0], acc_lo[WIDTH-2:0], 1'b1};
        end
    end

    // A zero divisor leaves the quotient all ones and the remainder equal to
    // |dividend|, so restoring the dividend sign yields rs_val for HI.
    always_comb begin
`ifdef MDU_FAST_MUL_EN
        product = {{WIDTH{1'b0}}, operand_b} * {{WIDTH{1'b0}}, acc_lo};
`else
        product = {acc_hi, acc_lo};
`endif
        prod_signed = neg_main ? -product : product;
        quot_fixed  = neg_main ? -acc_lo : acc_lo;
        rem_fixed   = neg_rem ? -acc_hi : acc_hi;
        if (is_div) begin
            fix_hi = rem_fixed;
            fix_lo = div_zero ? {WIDTH{1'b1}} : quot_fixed;
        end else begin
            fix_hi = prod_signed[2*WIDTH-1:WIDTH];
            fix_lo = prod_signed[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hi        <= '0;
            lo        <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            count     <= '0;
            acc_hi    <= '0;
            acc_lo    <= '0;
            operand_b <= '0;
            is_div    <= 1'b0;
            neg_main  <= 1'b0;
            neg_rem   <= 1'b0;
            div_zero  <= 1'b0;
        end else begin
            busy <= (next_state != IDLE);
            done <= (state == FIX);
            case (state)
                IDLE: begin
                    if (accept_op) begin
                        acc_hi    <= '0;
                        acc_lo    <= mag_a;
                        operand_b <= mag_b;
                        is_div    <= md_op[1];
                        neg_main  <= sign_a ^ sign_b;
                        neg_rem   <= sign_a;
                        div_zero  <= (rt_val == '0);
                        count     <= CW'(WIDTH - 1);
                    end else if (start && (md_op == 3'd4)) begin
                        hi <= rs_val;
                    end else if (start && (md_op == 3'd5)) begin
                        lo <= rs_val;
                    end
                end
                CALC: begin
                    {acc_hi, acc_lo} <= is_div ? div_next : mul_next;
                    count            <= count - CW'(1);
                end
                FIX: begin
                    hi <= fix_hi;
                    lo <= fix_lo;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: arithmetic reference model plus
// directed vectors with hand-computed results (honours MDU_FAST_MUL_EN).
module tb_mult_div_unit;

    localparam int W = 32;
`ifdef MDU_FAST_MUL_EN
    localparam int MUL_LAT = 2;
`else
    localparam int MUL_LAT = W + 2;
`endif
    localparam int DIV_LAT = W + 2;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [2:0]   md_op;
    logic [W-1:0] rs_val;
    logic [W-1:0] rt_val;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    mult_div_unit #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .md_op  (md_op),
        .rs_val (rs_val),
        .rt_val (rt_val),
        .busy   (busy),
        .done   (done),
        .hi     (hi),
        .lo     (lo)
    );

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %h want %h", name, actual, expected);
        end
    endtask

    // Reference results straight from the arithmetic definitions: {hi, lo}.
    function automatic logic [63:0] expected_result(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint signed la, lb;
        int signed     qa, qb;
        logic [63:0]   r;
        r = 64'h0;
        case (op)
            3'd0: begin
                la = longint'($signed(a));
                lb = longint'($signed(b));
                r  = 64'(la * lb);
            end
            3'd1: r = {32'h0, a} * {32'h0, b};
            3'd2: begin
                if (b == 32'h0) r = {a, 32'hFFFF_FFFF};
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = {32'h0, 32'h8000_0000};
                else begin
                    qa = $signed(a);
                    qb = $signed(b);
                    r  = {32'(qa % qb), 32'(qa / qb)};
                end
            end
            3'd3: begin
                if (b == 32'h0) r = {a, 32'hFFFF_FFFF};
                else r = {a % b, a / b};
            end
            default: r = 64'h0;
        endcase
        return r;
    endfunction

    function automatic int op_latency(input logic [2:0] op);
        return (op < 3'd2) ? MUL_LAT : DIV_LAT;
    endfunction

    // Model: a pending result becomes visible after the op's latency.
    logic [W-1:0] m_hi, m_lo;
    logic [63:0]  m_pending;
    bit           m_done;
    int           m_left;

    always @(posedge clk) begin
        m_done = 1'b0;
        if (rst) begin
            m_hi   = '0;
            m_lo   = '0;
            m_left = 0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
                m_hi   = m_pending[63:32];
                m_lo   = m_pending[31:0];
                m_done = 1'b1;
            end
        end else if (start) begin
            if (md_op < 3'd4) begin
                m_pending = expected_result(md_op, rs_val, rt_val);
                m_left    = op_latency(md_op) - 1;
            end else if (md_op == 3'd4) begin
                m_hi = rs_val;
            end else if (md_op == 3'd5) begin
                m_lo = rs_val;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            checkOutput("cyc_busy", 64'(busy), 64'(m_left > 0));
            checkOutput("cyc_done", 64'(done), 64'(m_done));
            checkOutput("cyc_hi", 64'(hi), 64'(m_hi));
            checkOutput("cyc_lo", 64'(lo), 64'(m_lo));
        end
    end

    // Called at a negedge: drives a one-cycle start, then scrambles operands.
    task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        start  = 1'b1;
        md_op  = op;
        rs_val = a;
        rt_val = b;
        @(negedge clk);
        start  = 1'b0;
        rs_val = $urandom;
        rt_val = $urandom;
    endtask

    task automatic runOp(input string name, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_hi, input logic [31:0] exp_lo, input int exp_lat);
        int n;
        applyStimulus(op, a, b);
        n = 1;
        while (done !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        checkOutput({name, "_lat"}, 64'(n), 64'(exp_lat));
        checkOutput({name, "_hi"}, 64'(hi), 64'(exp_hi));
        checkOutput({name, "_lo"}, 64'(lo), 64'(exp_lo));
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout want finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int cyc;
        int done_cnt;
        rst    = 1'b1;
        start  = 1'b0;
        md_op  = 3'd0;
        rs_val = '0;
        rt_val = '0;
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        checkOutput("rst_busy", 64'(busy), 64'h0);
        checkOutput("rst_done", 64'(done), 64'h0);
        checkOutput("rst_hi", 64'(hi), 64'h0);
        checkOutput("rst_lo", 64'(lo), 64'h0);
        rst = 1'b0;
        @(negedge clk);

        runOp("multu_max", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, MUL_LAT);
        runOp("mult_neg", 3'd0, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, MUL_LAT);
        runOp("div_neg", 3'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, DIV_LAT);
        runOp("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, DIV_LAT);
        runOp("divu_zero", 3'd3, 32'd100, 32'd0, 32'h0000_0064, 32'hFFFF_FFFF, DIV_LAT);
        runOp("div_zero_neg", 3'd2, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF, DIV_LAT);
        runOp("mult_minmin", 3'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, MUL_LAT);
        runOp("div_negdivisor", 3'd2, 32'd7, 32'hFFFF_FFFE, 32'h1, 32'hFFFF_FFFD, DIV_LAT);
        runOp("multu_carry", 3'd1, 32'h0001_0000, 32'h0001_0000, 32'h1, 32'h0, MUL_LAT);
        runOp("divu_big", 3'd3, 32'hFFFF_FFFF, 32'h10, 32'hF, 32'h0FFF_FFFF, DIV_LAT);

        applyStimulus(3'd4, 32'h1234_5678, 32'h0);
        checkOutput("mthi_hi", 64'(hi), 64'h1234_5678);
        checkOutput("mthi_done", 64'(done), 64'h0);
        applyStimulus(3'd5, 32'hAAAA_5555, 32'h0);
        checkOutput("mtlo_lo", 64'(lo), 64'hAAAA_5555);
        checkOutput("mtlo_busy", 64'(busy), 64'h0);
        applyStimulus(3'd6, 32'hDEAD_BEEF, 32'h1);
        checkOutput("rsvd_hi", 64'(hi), 64'h1234_5678);
        checkOutput("rsvd_busy", 64'(busy), 64'h0);

        // MTLO at cycle 3 and a second DIVU at cycle 5 must both be ignored.
        applyStimulus(3'd3, 32'd50, 32'd7);
        cyc = 1;
        @(negedge clk); cyc++;
        @(negedge clk); cyc++;
        start = 1'b1; md_op = 3'd5; rs_val = 32'h0000_DEAD;
        @(negedge clk); cyc++;
        start = 1'b0;
        checkOutput("busy_mtlo_lo", 64'(lo), 64'hAAAA_5555);
        checkOutput("busy_hold_hi", 64'(hi), 64'h1234_5678);
        @(negedge clk); cyc++;
        start = 1'b1; md_op = 3'd3; rs_val = 32'd1000; rt_val = 32'd3;
        @(negedge clk); cyc++;
        start = 1'b0;
        while (done !== 1'b1 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        checkOutput("busy_ign_lat", 64'(cyc), 64'(DIV_LAT));
        checkOutput("busy_ign_hi", 64'(hi), 64'h1);
        checkOutput("busy_ign_lo", 64'(lo), 64'h7);

        // Reset at cycle 10 of a running DIVU discards everything.
        applyStimulus(3'd3, 32'd1000, 32'd3);
        cyc = 1;
        while (cyc < 10) begin
            @(negedge clk);
            cyc++;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("midrst_busy", 64'(busy), 64'h0);
        checkOutput("midrst_hi", 64'(hi), 64'h0);
        checkOutput("midrst_lo", 64'(lo), 64'h0);
        done_cnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (done === 1'b1) done_cnt++;
        end
        checkOutput("midrst_no_done", 64'(done_cnt), 64'h0);

        runOp("after_rst", 3'd3, 32'd1000, 32'd3, 32'd1, 32'd333, DIV_LAT);

        @(negedge clk);
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
